// File: rtl/dmem_bridge_if.sv
// Memory-side bus of the data-memory bridge: a request/acknowledge
// handshake with latched address, write data and direction.
interface dmem_bridge_if;
  logic        mem_req;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // The bridge issues requests.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // The backing memory answers them.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the core's single-cycle SRAM-style access
// (CEN/WEN/A/D/Q) into a stalled request/ack transaction toward a slower
// backing memory. A wait counter bounds every request. A request that runs
// out of time sets a sticky error flag. A read that runs out of time
// returns a poison word.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [6:0]    A,
  input  logic [31:0]   D,
  output logic [31:0]   Q,
  output logic          stall,
  output logic          err,
  dmem_bridge_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // The last counter value that is still allowed to wait. A request that
  // reaches it without an ack has spent TIMEOUT cycles in REQ.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
  localparam logic [31:0] POISON   = 32'hDEAD_BEEF;

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic        timeout;
  logic        req_q;
  logic        we_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] q_q;
  logic        err_q;

  // The core's output enable has no meaning for this bridge.
  logic unused_oen;
  assign unused_oen = OEN;

  assign timeout = (wait_cnt == LAST_WAIT) && !mem.mem_ack;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so that every flop
  // samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and the combinational stall toward the core.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (!CEN) begin
          stall      = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem.mem_ack || timeout) next_state = DONE;
      end
      // DONE releases the core for one cycle and never looks at CEN.
      // A CEN still held low by the same instruction therefore cannot
      // re-issue the access.
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latches, wait counter, read-data return and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      q_q      <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      // mem_req is high exactly for the cycles spent in REQ.
      req_q <= (next_state == REQ);
      case (state)
        IDLE: begin
          if (!CEN) begin
            addr_q   <= A;
            wdata_q  <= D;
            we_q     <= ~WEN;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            if (!we_q) q_q <= mem.mem_rdata;
          end else if (timeout) begin
            err_q <= 1'b1;
            if (!we_q) q_q <= POISON;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign Q             = q_q;
  assign err           = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge. A cycle-by-cycle vector table covers
// reset, a read acked in its first REQ cycle, a write acked in its third
// REQ cycle, stray acks, and back-to-back reads. Hand-written sequences
// cover the timeout and a reset arriving in the middle of a request.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen, wen, oen;
  logic [6:0]  a;
  logic [31:0] d;
  logic [31:0] q;
  logic        stall, err;

  dmem_bridge_if bus ();

  dmem_bridge #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .CEN   (cen),
    .WEN   (wen),
    .OEN   (oen),
    .A     (a),
    .D     (d),
    .Q     (q),
    .stall (stall),
    .err   (err),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst, cen, wen;
    logic [6:0]  a;
    logic [31:0] d;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [6:0]  e_addr;
    logic [31:0] e_wdata, e_q;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, c, w, input logic [6:0] aa, input logic [31:0] dd,
    input logic ak, input logic [31:0] rd,
    input logic es, er, ew, input logic [6:0] ea, input logic [31:0] ewd, eq,
    input logic ee);
    vec_t v;
    v.rst = r; v.cen = c; v.wen = w; v.a = aa; v.d = dd; v.ack = ak; v.rdata = rd;
    v.e_stall = es; v.e_req = er; v.e_we = ew; v.e_addr = ea;
    v.e_wdata = ewd; v.e_q = eq; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, c, w, input logic [6:0] aa, input logic [31:0] dd,
                       input logic ak, input logic [31:0] rd);
    rst = r; cen = c; wen = w; a = aa; d = dd;
    bus.mem_ack = ak; bus.mem_rdata = rd;
  endtask

  // Move to the next cycle: inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic done;

    // Inputs for one cycle, then the outputs seen in that same cycle.
    // Columns: rst cen wen A D ack rdata | stall req we addr wdata Q err
    // Reset state.
    vecs.push_back(mk(0,1,1,7'h00,0,0,0,                     0,0,0,7'h00,0,0,0));
    // Read of 5, acked in the first REQ cycle.
    vecs.push_back(mk(0,0,1,7'h05,0,0,0,                     1,0,0,7'h00,0,0,0));
    vecs.push_back(mk(0,0,1,7'h05,0,1,32'h1234_5678,         1,1,0,7'h05,0,0,0));
    vecs.push_back(mk(0,0,1,7'h05,0,0,0,                     0,0,0,7'h05,0,32'h1234_5678,0));
    vecs.push_back(mk(0,1,1,7'h05,0,0,0,                     0,0,0,7'h05,0,32'h1234_5678,0));
    // Write to 7F, acked in the third REQ cycle. The core inputs wiggle
    // during REQ and must not reach the latched request.
    vecs.push_back(mk(0,0,0,7'h7F,32'hA5A5_0001,0,0,         1,0,0,7'h05,0,32'h1234_5678,0));
    vecs.push_back(mk(0,0,0,7'h7F,32'hA5A5_0001,0,0,         1,1,1,7'h7F,32'hA5A5_0001,32'h1234_5678,0));
    vecs.push_back(mk(0,0,1,7'h11,32'hFFFF_FFFF,0,0,         1,1,1,7'h7F,32'hA5A5_0001,32'h1234_5678,0));
    vecs.push_back(mk(0,1,1,7'h11,32'hFFFF_FFFF,1,32'hCAFE_F00D, 1,1,1,7'h7F,32'hA5A5_0001,32'h1234_5678,0));
    // DONE: CEN still low and a stray ack, both ignored.
    vecs.push_back(mk(0,0,0,7'h7F,32'hA5A5_0001,1,32'h0BAD_0BAD, 0,0,1,7'h7F,32'hA5A5_0001,32'h1234_5678,0));
    // Stray ack in IDLE with CEN=1.
    vecs.push_back(mk(0,1,1,7'h7F,0,1,32'h0BAD_0BAD,         0,0,1,7'h7F,32'hA5A5_0001,32'h1234_5678,0));
    vecs.push_back(mk(0,1,1,7'h00,0,0,0,                     0,0,1,7'h7F,32'hA5A5_0001,32'h1234_5678,0));
    // Back-to-back reads of 3 then 4 with CEN held low throughout.
    vecs.push_back(mk(0,0,1,7'h03,0,0,0,                     1,0,1,7'h7F,32'hA5A5_0001,32'h1234_5678,0));
    vecs.push_back(mk(0,0,1,7'h03,0,1,32'h3333_3333,         1,1,0,7'h03,0,32'h1234_5678,0));
    vecs.push_back(mk(0,0,1,7'h03,0,0,0,                     0,0,0,7'h03,0,32'h3333_3333,0));
    vecs.push_back(mk(0,0,1,7'h04,0,0,0,                     1,0,0,7'h03,0,32'h3333_3333,0));
    vecs.push_back(mk(0,0,1,7'h04,0,0,0,                     1,1,0,7'h04,0,32'h3333_3333,0));
    vecs.push_back(mk(0,0,1,7'h04,0,1,32'h4444_4444,         1,1,0,7'h04,0,32'h3333_3333,0));
    vecs.push_back(mk(0,0,1,7'h04,0,0,0,                     0,0,0,7'h04,0,32'h4444_4444,0));
    vecs.push_back(mk(0,1,1,7'h04,0,0,0,                     0,0,0,7'h04,0,32'h4444_4444,0));

    oen = 1'b1;
    drive(1, 1, 1, 7'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].cen, vecs[i].wen, vecs[i].a, vecs[i].d,
            vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), 32'(stall),         32'(vecs[i].e_stall));
      check($sformatf("v%0d_req", i),   32'(bus.mem_req),   32'(vecs[i].e_req));
      check($sformatf("v%0d_we", i),    32'(bus.mem_we),    32'(vecs[i].e_we));
      check($sformatf("v%0d_addr", i),  32'(bus.mem_addr),  32'(vecs[i].e_addr));
      check($sformatf("v%0d_wdata", i), bus.mem_wdata,      vecs[i].e_wdata);
      check($sformatf("v%0d_q", i),     q,                  vecs[i].e_q);
      check($sformatf("v%0d_err", i),   32'(err),           32'(vecs[i].e_err));
      next_cycle();
    end

    // Timeout: a read of 2A that is never acked holds REQ for exactly
    // four cycles, then returns the poison word and sets err.
    drive(0, 0, 1, 7'h2A, 0, 0, 0);
    @(negedge clk);
    check("to_issue_stall", 32'(stall), 32'd1);
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      next_cycle();
      @(negedge clk);
      if (bus.mem_req) n++;
      else             done = 1'b1;
    end
    check("to_left_req", 32'(done), 32'd1);
    check("to_req_cycles", n, 32'd4);
    check("to_err", 32'(err), 32'd1);
    check("to_q", q, 32'hDEAD_BEEF);
    check("to_done_stall", 32'(stall), 32'd0);
    // A later good write leaves err set and Q untouched.
    next_cycle();
    drive(0, 0, 0, 7'h01, 32'h0000_0001, 0, 0);
    next_cycle();
    drive(0, 0, 0, 7'h01, 32'h0000_0001, 1, 32'h5555_5555);
    @(negedge clk);
    check("to_wr_req", 32'(bus.mem_req), 32'd1);
    next_cycle();
    drive(0, 0, 0, 7'h01, 32'h0000_0001, 0, 0);
    @(negedge clk);
    check("to_wr_err", 32'(err), 32'd1);
    check("to_wr_q", q, 32'hDEAD_BEEF);
    check("to_wr_stall", 32'(stall), 32'd0);

    // Reset in the middle of a read; the ack two cycles later is ignored.
    next_cycle();
    drive(0, 0, 1, 7'h10, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    check("rm_in_req", 32'(bus.mem_req), 32'd1);
    next_cycle();
    drive(1, 1, 1, 7'h10, 0, 0, 0);
    next_cycle();
    drive(0, 1, 1, 7'h10, 0, 0, 0);
    @(negedge clk);
    check("rm_req", 32'(bus.mem_req), 32'd0);
    check("rm_q", q, 32'd0);
    check("rm_err", 32'(err), 32'd0);
    check("rm_addr", 32'(bus.mem_addr), 32'd0);
    check("rm_stall", 32'(stall), 32'd0);
    next_cycle();
    drive(0, 1, 1, 7'h10, 0, 1, 32'h7777_7777);
    next_cycle();
    drive(0, 1, 1, 7'h10, 0, 0, 0);
    @(negedge clk);
    check("rm_ack_q", q, 32'd0);
    check("rm_ack_req", 32'(bus.mem_req), 32'd0);
    check("rm_ack_err", 32'(err), 32'd0);
    check("rm_ack_stall", 32'(stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the rising-edge clock for all state.
REQ-003 The port rst SHALL be an input, 1 bit wide, and be the synchronous active-high reset.
REQ-004 The port CEN SHALL be an input, 1 bit wide: core chip enable, 0 = access requested.
REQ-005 The port WEN SHALL be an input, 1 bit wide: core write enable, 0 = write, 1 = read.
REQ-006 The port OEN SHALL be an input, 1 bit wide: core output enable, which the block ignores.
REQ-007 The port A SHALL be an input, 7 bits wide: core word address.
REQ-008 The port D SHALL be an input, 32 bits wide: core write data (the core's ReadData2).
REQ-009 The port Q SHALL be an output, 32 bits wide: read data returned to the core (the core's ReadDataMem).
REQ-010 The port stall SHALL be an output, 1 bit wide: 1 = core holds PC and all state this cycle.
REQ-011 The port mem_req SHALL be an output, 1 bit wide: request valid to the backing memory.
REQ-012 The port mem_we SHALL be an output, 1 bit wide: 1 = write, 0 = read.
REQ-013 The port mem_addr SHALL be an output, 7 bits wide: latched word address.
REQ-014 The port mem_wdata SHALL be an output, 32 bits wide: latched write data.
REQ-015 The port mem_ack SHALL be an input, 1 bit wide: memory completion, a single-cycle pulse.
REQ-016 The port mem_rdata SHALL be an input, 32 bits wide: read data, valid in the cycle mem_ack=1.
REQ-017 The port err SHALL be an output, 1 bit wide: sticky timeout flag.
REQ-018 The parameter TIMEOUT SHALL default to 255 and set the maximum number of REQ cycles without mem_ack.

Function
REQ-019 The FSM SHALL have three states (IDLE, REQ, DONE) and SHALL enter IDLE on reset.
REQ-020 In IDLE with CEN=0, the block SHALL latch A, D and ~WEN into mem_addr, mem_wdata and mem_we, and move to REQ.
REQ-021 In IDLE with CEN=1, the block SHALL stay in IDLE and leave all latched values unchanged.
REQ-022 stall SHALL be combinational: 1 when (IDLE and CEN=0) or in REQ; 0 otherwise.
REQ-023 mem_req SHALL be registered: 1 exactly while in REQ, 0 in IDLE and DONE.
REQ-024 mem_addr, mem_wdata and mem_we SHALL be stable for the whole REQ interval.
REQ-025 In REQ, if mem_ack=1, the block SHALL move to DONE on the next edge; mem_ack arriving in the first REQ cycle is legal.
REQ-026 On mem_ack for a read (mem_we=0), Q SHALL load mem_rdata; for a write, Q SHALL be unchanged.
REQ-027 Q SHALL hold its value until the next completed read or reset.
REQ-028 DONE SHALL last exactly one cycle with stall=0, then return to IDLE unconditionally; CEN is not sampled in DONE.
REQ-029 Because of REQ-028, a held CEN=0 from the same instruction SHALL NOT re-issue the access.
REQ-030 Minimum core-visible latency SHALL be 2 stalled cycles (IDLE, REQ) plus 1 release cycle (DONE).
REQ-031 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack.
REQ-032 If the counter reaches TIMEOUT without mem_ack, the block SHALL set err=1 and go to DONE.
REQ-033 On a timed-out read, Q SHALL load 32'hDEAD_BEEF.
REQ-034 err SHALL be sticky; only rst clears it.
REQ-035 mem_ack received in IDLE or DONE SHALL be ignored, with no state, Q or err change.
REQ-036 Changes on CEN, A, D or WEN during REQ SHALL be ignored.
REQ-037 The 7-bit address SHALL pass through unmodified, with no wrap or range checking.

Reset
REQ-038 While rst=1 at a rising edge, the block SHALL set state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Q=0, err=0 and wait counter=0.
REQ-039 A reset asserted mid-REQ SHALL drop mem_req at that edge, and any later mem_ack SHALL be ignored per REQ-035.
REQ-040 stall SHALL follow REQ-022 during reset, i.e. it is 0 unless CEN=0.

Verification
REQ-041 Read, ack in the first REQ cycle: the bench SHALL drive CEN=0, WEN=1, A=7'h05 and mem_rdata=32'h1234_5678, and expect stall=1 for 2 cycles, mem_addr=5, Q=32'h1234_5678 in DONE, and stall=0.
REQ-042 Write, ack after 3 cycles: the bench SHALL drive CEN=0, WEN=0, A=7'h7F, D=32'hA5A5_0001, and expect mem_we=1 and mem_wdata=32'hA5A5_0001 held for 3 cycles, Q unchanged, and exactly one mem_req interval.
REQ-043 Back-to-back accesses: the bench SHALL hold CEN=0 for 2 consecutive instructions (reads at 3 then 4), and expect two separate REQ intervals, each followed by DONE.
REQ-044 Timeout: the bench SHALL issue a read with mem_ack never asserted and TIMEOUT=4, and expect err=1 and Q=32'hDEAD_BEEF after 4 REQ cycles, then err to stay 1 on later good accesses.
REQ-045 Reset mid-REQ: the bench SHALL assert rst during REQ and pulse mem_ack 2 cycles later, and expect mem_req=0, Q=0, IDLE, and the ack to be ignored.
REQ-046 Stray ack: the bench SHALL pulse mem_ack in IDLE with CEN=1, and expect no change to Q, err or state.
